ram_cache_nway: RTL

RAM_CACHE_NWAY -- requirements
Module: ram_cache_nway

---
 rtl/ram_cache_pkg.sv | 25 ++
 rtl/ram_cache_way.sv | 58 +++++
 rtl/ram_cache_nway.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_cache_pkg
// Description : Shared types and constants for the N-way RAM cache.
//               It defines the controller state type, the counter width and
//               the saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_cache_pkg;

    localparam int CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RESP = 2'd2
    } cache_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_cache_way.sv
`default_nettype none
// ============================================================================
// Module      : ram_cache_way
// Description : One way of the set-associative cache. It holds the data, tag
//               and valid arrays. It provides a combinational lookup port and
//               a single synchronous write port.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_cache_way #(
    parameter int DATA_WIDTH = 16,
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  i_clear,
    input  logic [INDEX_BITS-1:0] i_lk_index,
    input  logic [TAG_BITS-1:0]   i_lk_tag,
    output logic                  o_hit,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [DATA_WIDTH-1:0] i_wr_data
);

    localparam int SETS = 1 << INDEX_BITS;

    logic [DATA_WIDTH-1:0] r_data [SETS];
    logic [TAG_BITS-1:0]   r_tag  [SETS];
    logic [SETS-1:0]       r_valid;

    // Valid bits are cleared by reset or by a flush. Any write marks its set valid.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_valid <= '0;
        end else if (i_clear) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // The data and tag storage needs no reset because valid gates every use.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[i_wr_index] <= i_wr_data;
            r_tag[i_wr_index]  <= i_wr_tag;
        end
    end

    assign o_valid   = r_valid[i_lk_index];
    assign o_hit     = r_valid[i_lk_index] && (r_tag[i_lk_index] == i_lk_tag);
    assign o_rd_data = r_data[i_lk_index];

endmodule
`default_nettype wire

// File: rtl/ram_cache_nway.sv
`default_nettype none
// ============================================================================
// Module      : ram_cache_nway
// Description : Write-through, optionally write-allocating, N-way
//               set-associative cache placed in front of a fixed-latency RAM.
//               Victim selection takes the lowest invalid way first and
//               otherwise uses a per-set round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_cache_nway
    import ram_cache_pkg::*;
#(
    parameter  int DATA_WIDTH         = 16,
    parameter  int RAM_REGISTER_COUNT = 1024,
    parameter  int INDEX_BITS         = 4,
    parameter  int WAYS               = 2,
    parameter  int RAM_LATENCY        = 2,
    parameter  int WRITE_ALLOCATE     = 1,
    localparam int ADDR_BITS          = $clog2(RAM_REGISTER_COUNT)
) (
    input  logic                  clk,
    input  logic                  resetN,
    output logic [DATA_WIDTH-1:0] cpu_in_m,
    input  logic [DATA_WIDTH-1:0] cpu_out_m,
    input  logic                  cpu_write_m,
    input  logic                  cpu_read_m,
    input  logic [ADDR_BITS-1:0]  cpu_data_addr,
    output logic                  cpu_stall,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] ram_in_m,
    output logic [DATA_WIDTH-1:0] ram_out_m,
    output logic                  ram_write_m,
    output logic                  ram_read_m,
    output logic [ADDR_BITS-1:0]  ram_data_addr,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;
    localparam int SETS       = 1 << INDEX_BITS;
    localparam int c_WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int c_LAT_W    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [c_LAT_W-1:0]    c_LAT_LAST = c_LAT_W'(RAM_LATENCY - 1);
    localparam logic [c_WAY_BITS-1:0] c_WAY_LAST = c_WAY_BITS'(WAYS - 1);

    cache_state_e          r_state;
    logic [ADDR_BITS-1:0]  r_miss_addr;
    logic [DATA_WIDTH-1:0] r_fill_data;
    logic [c_LAT_W-1:0]    r_lat_cnt;
    logic [CNT_WIDTH-1:0]  r_hit_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;
    logic [c_WAY_BITS-1:0] r_rr [SETS];

    logic [ADDR_BITS-1:0]  w_lk_addr;
    logic [INDEX_BITS-1:0] w_lk_index;
    logic [TAG_BITS-1:0]   w_lk_tag;
    logic [WAYS-1:0]       w_way_hit;
    logic [WAYS-1:0]       w_way_valid;
    logic [DATA_WIDTH-1:0] w_way_data [WAYS];
    logic [WAYS-1:0]       w_way_we;

    logic                  w_hit;
    logic [c_WAY_BITS-1:0] w_hit_way;
    logic [DATA_WIDTH-1:0] w_hit_data;
    logic [c_WAY_BITS-1:0] w_victim;
    logic                  w_found_free;

    logic                  w_idle;
    logic                  w_flush_now;
    logic                  w_rd_hit;
    logic                  w_rd_miss;
    logic                  w_fill_done;
    logic                  w_cpu_wr;
    logic                  w_alloc;
    logic [ADDR_BITS-1:0]  w_wr_addr;
    logic [INDEX_BITS-1:0] w_wr_index;
    logic [DATA_WIDTH-1:0] w_wr_data;

    // During a fill, the lookup follows the latched miss address. This
    // makes victim selection use the set that is being filled.
    assign w_lk_addr  = (r_state == FILL) ? r_miss_addr : cpu_data_addr;
    assign w_lk_index = w_lk_addr[INDEX_BITS-1:0];
    assign w_lk_tag   = w_lk_addr[ADDR_BITS-1:INDEX_BITS];

    assign w_idle      = (r_state == IDLE);
    assign w_flush_now = w_idle && flush;
    assign w_rd_hit    = w_idle && cpu_read_m && w_hit && !flush;
    assign w_rd_miss   = w_idle && cpu_read_m && !w_hit && !flush;
    assign w_fill_done = (r_state == FILL) && (r_lat_cnt == c_LAT_LAST);

    assign cpu_stall     = resetN && (w_rd_miss || (r_state == FILL));
    assign ram_read_m    = resetN && w_rd_miss;
    assign ram_write_m   = resetN && cpu_write_m && !cpu_stall;
    assign ram_out_m     = cpu_out_m;
    assign ram_data_addr = (r_state == FILL) ? r_miss_addr : cpu_data_addr;
    assign cpu_in_m      = (r_state == RESP) ? r_fill_data : w_hit_data;
    assign hit_count     = r_hit_cnt;
    assign miss_count    = r_miss_cnt;

    // A CPU write updates the cache only when it is not stalled. A write during
    // a flush cycle is skipped because the flush invalidates the line anyway.
    assign w_cpu_wr   = resetN && cpu_write_m && !cpu_stall && !w_flush_now && (r_state != FILL);
    assign w_alloc    = w_fill_done || (w_cpu_wr && !w_hit && (WRITE_ALLOCATE != 0));
    assign w_wr_addr  = w_fill_done ? r_miss_addr : cpu_data_addr;
    assign w_wr_index = w_wr_addr[INDEX_BITS-1:0];
    assign w_wr_data  = w_fill_done ? ram_in_m : cpu_out_m;

    // Priority hit mux. Tags are unique within a set, so at most one way hits.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_hit_data = w_way_data[0];
        for (int i = 0; i < WAYS; i++) begin
            if (w_way_hit[i] && !w_hit) begin
                w_hit      = 1'b1;
                w_hit_way  = c_WAY_BITS'(i);
                w_hit_data = w_way_data[i];
            end
        end
    end

    // Choose the victim: the lowest invalid way, otherwise the round-robin pointer of the set.
    always_comb begin
        w_victim     = r_rr[w_lk_index];
        w_found_free = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!w_way_valid[i] && !w_found_free) begin
                w_victim     = c_WAY_BITS'(i);
                w_found_free = 1'b1;
            end
        end
    end

    generate
        for (genvar i = 0; i < WAYS; i++) begin : g_way
            assign w_way_we[i] = resetN && (w_fill_done
                ? (w_victim == c_WAY_BITS'(i))
                : (w_cpu_wr && (w_hit ? (w_hit_way == c_WAY_BITS'(i))
                                      : ((WRITE_ALLOCATE != 0) && (w_victim == c_WAY_BITS'(i))))));

            ram_cache_way #(
                .DATA_WIDTH (DATA_WIDTH),
                .INDEX_BITS (INDEX_BITS),
                .TAG_BITS   (TAG_BITS)
            ) u_way (
                .clk        (clk),
                .resetN     (resetN),
                .i_clear    (w_flush_now),
                .i_lk_index (w_lk_index),
                .i_lk_tag   (w_lk_tag),
                .o_hit      (w_way_hit[i]),
                .o_valid    (w_way_valid[i]),
                .o_rd_data  (w_way_data[i]),
                .i_wr_en    (w_way_we[i]),
                .i_wr_index (w_wr_index),
                .i_wr_tag   (w_wr_addr[ADDR_BITS-1:INDEX_BITS]),
                .i_wr_data  (w_wr_data)
            );
        end
    endgenerate

    // Miss controller: wait through the RAM latency, capture the fill, then present it for one cycle.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_lat_cnt   <= '0;
            r_miss_addr <= '0;
            r_fill_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rd_miss) begin
                        r_state     <= FILL;
                        r_miss_addr <= cpu_data_addr;
                        r_lat_cnt   <= '0;
                    end
                end
                FILL: begin
                    if (r_lat_cnt == c_LAT_LAST) begin
                        r_state     <= RESP;
                        r_fill_data <= ram_in_m;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Saturating counters. Only reads that start in IDLE are counted.
    always_ff @(posedge clk) begin
        if (!resetN || w_flush_now) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_rd_hit) begin
                r_hit_cnt <= sat_inc(r_hit_cnt);
            end
            if (w_rd_miss) begin
                r_miss_cnt <= sat_inc(r_miss_cnt);
            end
        end
    end

    // The round-robin pointer of a set advances on every allocation into that set.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
            end
        end else if (w_alloc) begin
            r_rr[w_wr_index] <= (r_rr[w_wr_index] == c_WAY_LAST) ? '0 : r_rr[w_wr_index] + 1'b1;
        end
    end

endmodule
`default_nettype wire
